// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pipe_pkg                                              |
// | Purpose  : Shared opcodes, FSM state encoding and flag bit indices   |
// |            for the pipelined ALU.                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_pipe_pkg;

  // MIPS funct codes understood by the ALU
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Bit positions inside the Flags vector {illegal, ovf, carry, neg, zero}
  localparam int F_ZERO    = 0;
  localparam int F_NEG     = 1;
  localparam int F_CARRY   = 2;
  localparam int F_OVF     = 3;
  localparam int F_ILLEGAL = 4;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_mul_seq                                               |
// | Purpose  : Iterative shift-add multiplier, one partial product per   |
// |            cycle. Raises done once all N iterations have been made.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int c_cnt_w = $clog2(N + 1);

  logic [2*N-1:0]     r_acc;
  logic [2*N-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [c_cnt_w-1:0] r_count;
  logic               r_busy;

  // Load operands on start, then add/shift once per cycle until the count hits zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_count  <= c_cnt_w'(N);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_count != '0) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - 1'b1;
      end else begin
        // The FSM consumes the product in this cycle
        r_busy <= 1'b0;
      end
    end
  end

  assign done    = r_busy && (r_count == '0);
  assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pipe                                                  |
// | Purpose  : Registered MIPS funct-coded ALU with valid/ready on both  |
// |            sides and per-result status flags.                        |
// | Config   : ALU_PIPE_MUL_EN enables the iterative multiply (011000).  |
// |            Without it that opcode is reported as illegal.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  input  logic [5:0]   OpCode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [4:0]   Flags
);

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0] r_result;
  logic [4:0]   r_flags;

  logic         w_accept;
  logic         w_is_mul;
  logic         w_load_alu;
  logic         w_load_mul;
  logic         w_mul_done;
  logic [N-1:0] w_mul_result;
  logic [4:0]   w_mul_flags;

  logic [SHW-1:0] w_sh;
  logic [N:0]     w_sum;
  logic [N:0]     w_diff;
  logic [N-1:0]   w_alu_result;
  logic [4:0]     w_alu_flags;

  assign in_ready  = (r_state == IDLE) || ((r_state == OUT) && out_ready);
  assign out_valid = (r_state == OUT);
  assign w_accept  = in_valid && in_ready;
  assign Result    = r_result;
  assign Flags     = r_flags;

`ifdef ALU_PIPE_MUL_EN
  logic           w_mul_start;
  logic [2*N-1:0] w_product;

  assign w_is_mul    = (OpCode == OP_MULT);
  assign w_mul_start = w_accept && w_is_mul;

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (BusA),
    .b       (BusB),
    .done    (w_mul_done),
    .product (w_product)
  );

  // Product flags: overflow whenever the upper half of the full product is non-zero
  always_comb begin
    w_mul_result          = w_product[N-1:0];
    w_mul_flags           = '0;
    w_mul_flags[F_ZERO]   = (w_product[N-1:0] == '0);
    w_mul_flags[F_NEG]    = w_product[N-1];
    w_mul_flags[F_OVF]    = |w_product[2*N-1:N];
  end
`else
  assign w_is_mul     = 1'b0;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = '0;
  assign w_mul_flags  = '0;
`endif

  assign w_sh   = BusB[SHW-1:0];
  assign w_sum  = {1'b0, BusA} + {1'b0, BusB};
  assign w_diff = {1'b0, BusA} - {1'b0, BusB};

  // Single-cycle datapath; shifts by sh>=N naturally give 0 (logical) or sign fill (arithmetic)
  always_comb begin
    w_alu_result = '0;
    w_alu_flags  = '0;
    case (OpCode)
      OP_ADD: begin
        w_alu_result         = w_sum[N-1:0];
        w_alu_flags[F_CARRY] = w_sum[N];
        w_alu_flags[F_OVF]   = (BusA[N-1] == BusB[N-1]) && (w_sum[N-1] != BusA[N-1]);
      end
      OP_SUB: begin
        w_alu_result         = w_diff[N-1:0];
        w_alu_flags[F_CARRY] = w_diff[N];
        w_alu_flags[F_OVF]   = (BusA[N-1] != BusB[N-1]) && (w_diff[N-1] != BusA[N-1]);
      end
      OP_AND: w_alu_result = BusA & BusB;
      OP_OR:  w_alu_result = BusA | BusB;
      OP_XOR: w_alu_result = BusA ^ BusB;
      OP_NOR: w_alu_result = ~(BusA | BusB);
      OP_SLL: w_alu_result = BusB << w_sh;
      OP_SRL: w_alu_result = BusA >> w_sh;
      OP_SRA: w_alu_result = $signed(BusA) >>> w_sh;
      OP_SLT: w_alu_result = {{(N-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
`ifdef ALU_PIPE_MUL_EN
      // Result comes from the multiplier; this path is never loaded for mult
      OP_MULT: w_alu_result = '0;
`endif
      default: w_alu_flags[F_ILLEGAL] = 1'b1;
    endcase
    w_alu_flags[F_ZERO] = (w_alu_result == '0);
    w_alu_flags[F_NEG]  = w_alu_result[N-1];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and load decisions
  always_comb begin
    w_state_next = r_state;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_next = MUL;
          end else begin
            w_state_next = OUT;
            w_load_alu   = 1'b1;
          end
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_next = OUT;
          w_load_mul   = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (w_accept) begin
            if (w_is_mul) begin
              w_state_next = MUL;
            end else begin
              w_state_next = OUT;
              w_load_alu   = 1'b1;
            end
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result/flag registers; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_load_alu) begin
      r_result <= w_alu_result;
      r_flags  <= w_alu_flags;
    end else if (w_load_mul) begin
      r_result <= w_mul_result;
      r_flags  <= w_mul_flags;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_pipe                                               |
// | Purpose  : Directed self-checking bench for alu_pipe (N=8).          |
// |            Multiply tests are selected by ALU_PIPE_MUL_EN.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_pipe;

  localparam logic [5:0] T_SLL  = 6'b000000;
  localparam logic [5:0] T_SRL  = 6'b000010;
  localparam logic [5:0] T_SRA  = 6'b000011;
  localparam logic [5:0] T_MULT = 6'b011000;
  localparam logic [5:0] T_ADD  = 6'b100000;
  localparam logic [5:0] T_SUB  = 6'b100010;
  localparam logic [5:0] T_AND  = 6'b100100;
  localparam logic [5:0] T_OR   = 6'b100101;
  localparam logic [5:0] T_XOR  = 6'b100110;
  localparam logic [5:0] T_NOR  = 6'b100111;
  localparam logic [5:0] T_SLT  = 6'b101010;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] BusA;
  logic [7:0] BusB;
  logic [5:0] OpCode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Result;
  logic [4:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BusA      (BusA),
    .BusB      (BusB),
    .OpCode    (OpCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Flags     (Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present a bundle at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    OpCode   = op;
    BusA     = a;
    BusB     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    OpCode    = 6'h0;
    BusA      = 8'h0;
    BusB      = 8'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, Result, Flags} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_values: got {ov,res,flags}=%h, expected %h", {out_valid, Result, Flags}, 14'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got {in_ready,ov}=%b, expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_add_sub();
    logic [5:0] op [4];
    logic [7:0] a  [4];
    logic [7:0] b  [4];
    logic [7:0] er [4];
    logic [4:0] ef [4];
    op = '{T_ADD, T_ADD, T_SUB, T_SUB};
    a  = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    b  = '{8'h01, 8'h01, 8'h01, 8'h01};
    er = '{8'h80, 8'h00, 8'hFF, 8'h7F};
    ef = '{5'h0A, 5'h05, 5'h06, 5'h08};
    for (int i = 0; i < 4; i++) begin
      issue(op[i], a[i], b[i]);
      n_checks++;
      if ({out_valid, Result, Flags} !== {1'b1, er[i], ef[i]}) begin
        n_fail++;
        $display("FAIL add_sub[%0d]: got ov=%b res=%h flags=%h, expected ov=1 res=%h flags=%h",
                 i, out_valid, Result, Flags, er[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_logic();
    logic [5:0] op [4];
    logic [7:0] er [4];
    logic [4:0] ef [4];
    op = '{T_AND, T_OR, T_XOR, T_NOR};
    er = '{8'h30, 8'hFC, 8'hCC, 8'h03};
    ef = '{5'h00, 5'h02, 5'h02, 5'h00};
    for (int i = 0; i < 4; i++) begin
      issue(op[i], 8'hF0, 8'h3C);
      n_checks++;
      if ({out_valid, Result, Flags} !== {1'b1, er[i], ef[i]}) begin
        n_fail++;
        $display("FAIL logic[%0d]: got ov=%b res=%h flags=%h, expected ov=1 res=%h flags=%h",
                 i, out_valid, Result, Flags, er[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_shift_slt();
    logic [5:0] op [5];
    logic [7:0] a  [5];
    logic [7:0] b  [5];
    logic [7:0] er [5];
    logic [4:0] ef [5];
    op = '{T_SRA, T_SRL, T_SLL, T_SLT, T_SLT};
    a  = '{8'h90, 8'h90, 8'h55, 8'hFF, 8'h01};
    b  = '{8'h0B, 8'h0B, 8'h03, 8'h01, 8'hFF};
    er = '{8'hF2, 8'h12, 8'h18, 8'h01, 8'h00};
    ef = '{5'h02, 5'h00, 5'h00, 5'h00, 5'h01};
    for (int i = 0; i < 5; i++) begin
      issue(op[i], a[i], b[i]);
      n_checks++;
      if ({out_valid, Result, Flags} !== {1'b1, er[i], ef[i]}) begin
        n_fail++;
        $display("FAIL shift_slt[%0d]: got ov=%b res=%h flags=%h, expected ov=1 res=%h flags=%h",
                 i, out_valid, Result, Flags, er[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    issue(6'h3F, 8'h12, 8'h34);
    n_checks++;
    if ({out_valid, Result, Flags} !== {1'b1, 8'h00, 5'h11}) begin
      n_fail++;
      $display("FAIL illegal_3f: got ov=%b res=%h flags=%h, expected ov=1 res=00 flags=11",
               out_valid, Result, Flags);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      issue(T_ADD, 8'(16 * i + 1), 8'h02);
      n_checks++;
      if ({out_valid, Result} !== {1'b1, 8'(16 * i + 3)}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got ov=%b res=%h, expected ov=1 res=%h",
                 i, out_valid, Result, 8'(16 * i + 3));
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_idle: got ov=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    issue(T_ADD, 8'h05, 8'h06);
    in_valid = 1'b1;
    OpCode   = T_ADD;
    BusA     = 8'h20;
    BusB     = 8'h20;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({in_ready, out_valid, Result} !== {1'b0, 1'b1, 8'h0B}) begin
        n_fail++;
        $display("FAIL back_pressure_hold[%0d]: got in_ready=%b ov=%b res=%h, expected in_ready=0 ov=1 res=0b",
                 c, in_ready, out_valid, Result);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, Result, Flags} !== {1'b1, 8'h40, 5'h00}) begin
      n_fail++;
      $display("FAIL back_pressure_release: got ov=%b res=%h flags=%h, expected ov=1 res=40 flags=00",
               out_valid, Result, Flags);
    end
    @(negedge clk);
  endtask

  task automatic test_out_reset();
    out_ready = 1'b0;
    issue(T_ADD, 8'h11, 8'h92);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, Result, Flags} !== 14'h0) begin
      n_fail++;
      $display("FAIL out_reset: got {ov,res,flags}=%h, expected %h", {out_valid, Result, Flags}, 14'h0);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL out_reset_release: got {in_ready,ov}=%b, expected 10", {in_ready, out_valid});
    end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    issue(T_MULT, 8'd13, 8'd11);
    // A stray bundle offered during MUL must be ignored
    in_valid = 1'b1;
    OpCode   = T_ADD;
    BusA     = 8'h01;
    BusB     = 8'h01;
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: got ov=%b in_ready=%b, expected 0 0", c, out_valid, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, Result, Flags} !== {1'b1, 8'h8F, 5'h02}) begin
      n_fail++;
      $display("FAIL mul_13x11: got ov=%b res=%h flags=%h, expected ov=1 res=8f flags=02",
               out_valid, Result, Flags);
    end
    issue(T_MULT, 8'h10, 8'h10);
    repeat (9) @(negedge clk);
    n_checks++;
    if ({out_valid, Result, Flags} !== {1'b1, 8'h00, 5'h09}) begin
      n_fail++;
      $display("FAIL mul_ovf: got ov=%b res=%h flags=%h, expected ov=1 res=00 flags=09",
               out_valid, Result, Flags);
    end
    @(negedge clk);
  endtask

  task automatic test_mul_reset();
    logic stale;
    issue(T_MULT, 8'h03, 8'h05);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, Result, Flags} !== 14'h0) begin
      n_fail++;
      $display("FAIL mul_reset: got {ov,res,flags}=%h, expected %h", {out_valid, Result, Flags}, 14'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_reset_release: got {in_ready,ov}=%b, expected 10", {in_ready, out_valid});
    end
    stale = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_reset_stale: got out_valid seen=%b, expected 0", stale);
    end
  endtask
`else
  task automatic test_mul_disabled();
    issue(T_MULT, 8'd13, 8'd11);
    n_checks++;
    if ({out_valid, Result, Flags} !== {1'b1, 8'h00, 5'h11}) begin
      n_fail++;
      $display("FAIL mul_disabled: got ov=%b res=%h flags=%h, expected ov=1 res=00 flags=11",
               out_valid, Result, Flags);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_shift_slt();
    test_illegal();
    test_back_to_back();
    test_back_pressure();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_out_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's combinational ALU. It executes the same MIPS funct-coded operations, plus variable shifts, `sll`, `slt` and an optional iterative multiply, on `N`-bit operands. Operands enter and results leave over valid/ready handshakes, and each result carries status flags. It sits between the operand/decode stage and the result write-back stage of the datapath.

## Interface
- `N`, 8: operand and result width, ≥ 4.
- `SHW`, `$clog2(N)`: shift-amount width, taken from `BusB[SHW-1:0]`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: the operand/opcode bundle is valid.
- `in_ready` out 1: the block accepts the bundle this cycle.
- `BusA` in N: operand A, signed for `sra`/`slt`/overflow.
- `BusB` in N: operand B; its low `SHW` bits are the shift amount.
- `OpCode` in 6: funct code.
- `out_valid` out 1: `Result` and `Flags` are valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `Result` out N: registered result.
- `Flags` out 5: `{illegal, ovf, carry, neg, zero}`, registered.

## Operation
- Opcodes and results:
  - 100000 add.
  - 100010 sub.
  - 100100 and.
  - 100101 or.
  - 100110 xor.
  - 100111 nor.
  - 000000 sll, `BusB<<sh`.
  - 000010 srl, `BusA>>sh`.
  - 000011 sra, `BusA>>>sh`.
  - 101010 slt: result 1 if `BusA<BusB` signed, else 0.
  - 011000 mult: low N bits of the product (macro-dependent).
- Any other opcode: `Result`=0 and `illegal`=1.
- Shift amount `sh` is `BusB[SHW-1:0]`. For `sh≥N` (possible only when N is not a power of two), sll and srl give 0 and sra gives N copies of `BusA[N-1]`.
- `zero` = `(Result==0)` and `neg` = `Result[N-1]`, for every opcode including illegal.
- `carry`:
  - add: the carry-out of the N-bit unsigned sum.
  - sub: the borrow, i.e. `BusA<BusB` unsigned.
  - All other opcodes: 0.
- `ovf`:
  - add/sub: signed overflow.
  - mult: 1 if the high N bits of the unsigned 2N product are non-zero.
  - All other opcodes: 0.
- FSM states: IDLE, MUL, OUT. Reset state is IDLE.
  - IDLE: `in_ready`=1. On `in_valid`, a non-mult op goes to OUT with `Result`/`Flags` loaded; mult goes to MUL with the operands latched and a counter set to N.
  - MUL: `in_ready`=0. One shift-add iteration per cycle; the counter decrements. When the counter reaches 0, load `Result`/`Flags` and go to OUT.
  - OUT: `out_valid`=1 and `in_ready`=`out_ready`.
    - If `out_ready` and `in_valid` are both high, accept the new bundle in the same cycle: a non-mult op stays in OUT with new data; mult goes to MUL.
    - If `out_ready` is high and `in_valid` is low, go to IDLE.
    - If `out_ready` is low, hold `Result`/`Flags` unchanged.
- Inputs are ignored whenever `in_ready`=0, whatever `in_valid` is.

## Timing
- Reset values: `out_valid`=0, `Result`=0, `Flags`=0, state=IDLE. `in_ready`=1 in the first cycle after reset deasserts.
- Reset asserted mid-MUL or in OUT aborts the operation, returns to the reset values in the next cycle, and no result is produced.
- Non-mult op accepted at edge k: `out_valid` is high from edge k+1.
- Mult accepted at edge k: `out_valid` is high from edge k+N+1.
- Throughput: one non-mult op per cycle when `out_ready` is held high. A mult occupies N+1 cycles.

## Configuration
- `ALU_PIPE_MUL_EN` defined:
  - 011000 is legal and executes as above.
  - The MUL state and the `alu_mul_seq` instance are compiled in.
- `ALU_PIPE_MUL_EN` undefined:
  - 011000 is an illegal opcode: `Result`=0, `illegal`=1, `zero`=1.
  - The MUL state is unreachable and removed; every accepted op reaches OUT in one cycle.

## Structure
- Package `alu_pipe_pkg` holds:
  - the opcode localparams;
  - the state enum `{IDLE, MUL, OUT}`;
  - the flag bit indices (`F_ZERO`=0, `F_NEG`=1, `F_CARRY`=2, `F_OVF`=3, `F_ILLEGAL`=4).
- Sub-module `alu_mul_seq` contains:
  - the shift-add multiplier: a 2N accumulator, the multiplicand, the multiplier shift register and a counter;
  - the `start`/`done` signals to the FSM.
- It is instantiated only under `ALU_PIPE_MUL_EN`.
- The combinational op datapath and the flags stay in the top module.

## Test plan
- Add with N=8, `BusA`=0x7F, `BusB`=0x01, accepted at edge 0 → at edge 1 `Result`=0x80, `ovf`=1, `carry`=0, `neg`=1, `zero`=0.
- Sub 0x00−0x01 → `Result`=0xFF, `carry`=1, `ovf`=0, `neg`=1. Sub 0x80−0x01 → `Result`=0x7F, `ovf`=1.
- sra of 0x90 by `BusB`=0x0B (sh=3) → 0xF2. srl of the same → 0x12. sll of `BusB`=0x03 by `BusB[2:0]`=3 → 0x18. slt 0xFF<0x01 → 1.
- Back-to-back and back-pressure: 4 adds on consecutive cycles with `out_ready`=1 → 4 results on consecutive cycles. With `out_ready` low for 3 cycles → `Result` is held stable and `in_ready`=0 for those 3 cycles. Illegal opcode 0x3F → `Result`=0, `Flags`=0x11.
- With `ALU_PIPE_MUL_EN`:
  - 13×11 accepted at edge 0 → `out_valid` at edge 9, `Result`=0x8F, `ovf`=0.
  - 0x10×0x10 → `Result`=0x00, `zero`=1, `ovf`=1.
  - `in_ready`=0 during MUL.
  - Without the macro, the same opcode → `illegal`=1 at edge 1.
- Reset asserted during the 4th MUL cycle → at the next edge `out_valid`=0, `Result`=0, `Flags`=0, and `in_ready`=1 in the cycle after reset deasserts. No stale product appears afterwards.
